// File: rtl/mem_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | rexta (mem_arbiter_pkg) - shared types for the I/D bus arbiter    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package rexta;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_I = 1'b0,
    M_D = 1'b1
  } arb_master_t;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_timeout.sv
// +------------------------------------------------------------------+
// | arb_timeout - per-transaction wait counter with expiry flag       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module arb_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int              c_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_W-1:0]  c_LAST = c_W'(TIMEOUT_CYCLES - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry marks the last allowed wait cycle so termination lands on it.
  assign o_expired = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +------------------------------------------------------------------+
// | mem_arbiter - round-robin I/D arbiter onto one cs/ready slave     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import rexta::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_cs,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  arb_master_t r_last_grant;
  arb_master_t w_grant_m;

  logic        w_grant;
  logic        w_done;
  logic        w_timeout;
  logic        w_expired;
  logic        w_cand_i;
  logic        w_cand_d;
  logic [31:0] w_rd;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bus_err;
  logic [31:0] r_err_addr;

  arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_grant || w_done),
    .i_inc    ((r_state != IDLE) && !m_ready),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_grant      = 1'b0;
    w_grant_m    = M_I;
    w_next_state = r_state;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    i_rdata      = 32'h0;
    d_rdata      = 32'h0;

    if (r_state != IDLE) begin
      w_done    = m_ready || w_expired;
      w_timeout = !m_ready && w_expired;
    end
    w_rd = w_timeout ? ERR_RDATA : m_rdata;

    // The completing master may not win the slot it is just leaving.
    w_cand_i = i_req && !(w_done && (r_state == BUSY_I));
    w_cand_d = d_req && !(w_done && (r_state == BUSY_D));

    if ((r_state == IDLE) || w_done) begin
      if (w_cand_i && w_cand_d) begin
        w_grant   = 1'b1;
        w_grant_m = (r_last_grant == M_D) ? M_I : M_D;
      end else if (w_cand_i) begin
        w_grant   = 1'b1;
        w_grant_m = M_I;
      end else if (w_cand_d) begin
        w_grant   = 1'b1;
        w_grant_m = M_D;
      end
    end

    if (w_done) begin
      w_next_state = IDLE;
    end
    if (w_grant) begin
      w_next_state = (w_grant_m == M_I) ? BUSY_I : BUSY_D;
    end

    if (w_done && (r_state == BUSY_I)) begin
      i_ready = 1'b1;
      i_rdata = w_rd;
    end
    if (w_done && (r_state == BUSY_D)) begin
      d_ready = 1'b1;
      d_rdata = w_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= M_D;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'h0;
      r_bus_err    <= 1'b0;
      r_err_addr   <= 32'h0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_grant_m;
        if (w_grant_m == M_I) begin
          r_we    <= 1'b0;
          r_addr  <= i_addr;
          r_wdata <= 32'h0;
          r_wstrb <= 4'h0;
        end else begin
          r_we    <= d_we;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
          r_wstrb <= d_wstrb;
        end
      end
      // A clear coinciding with a new timeout re-arms capture of the new address.
      if (w_timeout) begin
        r_bus_err <= 1'b1;
        if (!r_bus_err || err_clr) begin
          r_err_addr <= r_addr;
        end
      end else if (err_clr) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  assign m_cs     = (r_state != IDLE);
  assign m_we     = r_we;
  assign m_addr   = r_addr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;
  assign bus_err  = r_bus_err;
  assign err_addr = r_err_addr;

endmodule

`default_nettype wire
